iccm_load_ctrl: RTL and testbench

Boot-time loader that sequences the ICCM programming port of the instruction-memory TLUL wrapper. It receives a byte stream from the programming interface (UART/SPI receiver) and assembles little-endian 32-bit words. It writes them to consecutive ICCM addresses through the `iccm_cntrl_*` pins and holds the core in reset until the image is complete. It sits between the programming receiver and the instruction-memory wrapper, and drives the core reset request to the reset manager.

---
 rtl/iccm_load_ctrl.sv | 144 ++++++++++++++
 tb/tb_iccm_load_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_load_ctrl.sv
// Boot loader: assembles little-endian words from a byte stream and writes them
// to consecutive ICCM addresses, holding the core in reset until the image is in.
module iccm_load_ctrl #(
  parameter int unsigned AddrW         = 12,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_byte_i,
  output logic             rx_ready_o,
  output logic [31:0]      iccm_cntrl_data_o,
  output logic [AddrW-1:0] iccm_cntrl_addr_o,
  output logic             iccm_cntrl_we_o,
  output logic             core_rst_no,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      checksum_o
);

  localparam int unsigned     TmoW    = $clog2(TimeoutCycles + 1);
  localparam logic [32:0]     Depth   = 33'd1 << AddrW;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StIdle, StHdr, StLoad, StWrite, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [AddrW-1:0]  last_addr_q, last_addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       sum_q, sum_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              accept;
  logic              word_done;
  logic              stalled;
  logic [31:0]       word;

  assign rx_ready_o = (state_q == StHdr) || (state_q == StLoad);
  assign accept     = rx_valid_i && rx_ready_o;
  assign word_done  = accept && (byte_cnt_q == 2'd3);
  assign stalled    = !accept && (byte_cnt_q != 2'd0);
  assign word       = {rx_byte_i, asm_q};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    data_d      = data_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    if (accept) byte_cnt_d = byte_cnt_q + 2'd1;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d    = StHdr;
          byte_cnt_d = '0;
          addr_d     = '0;
          sum_d      = '0;
        end
      end
      StHdr, StLoad: begin
        // Timeout only guards a partially assembled word; idling between words is legal.
        if (stalled) tmo_d = tmo_q + TmoW'(1);
        if (stalled && (tmo_q == TmoLast)) begin
          state_d = StErr;
        end else if (word_done) begin
          if (state_q == StHdr) begin
            if (word == '0) begin
              state_d = StDone;
            end else if ({1'b0, word} > Depth) begin
              state_d = StErr;
            end else begin
              state_d     = StLoad;
              addr_d      = '0;
              last_addr_d = word[AddrW-1:0] - AddrW'(1);
            end
          end else begin
            data_d  = word;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        sum_d = sum_q + data_q;
        if (addr_q == last_addr_q) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrW'(1);
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      data_q      <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
    end
  end

  // Lower three bytes of the word in flight; the fourth is taken straight from the input.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      unique case (byte_cnt_q)
        2'd0:    asm_q[7:0]   <= rx_byte_i;
        2'd1:    asm_q[15:8]  <= rx_byte_i;
        2'd2:    asm_q[23:16] <= rx_byte_i;
        default: ;
      endcase
    end
  end

  assign iccm_cntrl_we_o   = (state_q == StWrite);
  assign iccm_cntrl_data_o = data_q;
  assign iccm_cntrl_addr_o = addr_q;
  assign busy_o            = (state_q == StHdr) || (state_q == StLoad) || (state_q == StWrite);
  assign done_o            = (state_q == StDone);
  assign err_o             = (state_q == StErr);
  assign core_rst_no       = (state_q == StDone);
  assign checksum_o        = sum_q;

endmodule

// File: tb/tb_iccm_load_ctrl.sv
// Directed bench for iccm_load_ctrl: write scoreboard plus per-cycle output rules.
module tb_iccm_load_ctrl;

  localparam int AddrW = 12;
  localparam int Tmo   = 16;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             rx_ready_o;
  logic [31:0]      data;
  logic [AddrW-1:0] addr;
  logic             we;
  logic             core_rst_no;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [31:0]      checksum_o;

  iccm_load_ctrl #(.AddrW(AddrW), .TimeoutCycles(Tmo)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .rx_valid_i(rx_valid),
    .rx_byte_i(rx_byte), .rx_ready_o(rx_ready_o), .iccm_cntrl_data_o(data),
    .iccm_cntrl_addr_o(addr), .iccm_cntrl_we_o(we), .core_rst_no(core_rst_no),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AddrW-1:0] a;
    logic [31:0]      d;
  } wr_t;

  wr_t              exp_q[$];
  logic [31:0]      exp_sum;
  logic [31:0]      img [0:4095];
  logic [AddrW-1:0] last_addr;
  logic             prev_busy;
  int               tests, fails, nwrites, w0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Output rules every cycle; writes are checked against the queue of expected words.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        exp_sum = '0;
        check("rst_ctrl", 32'({rx_ready_o, we, core_rst_no, busy_o, done_o, err_o}), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_checksum", checksum_o, 32'd0);
      end else begin
        if (busy_o && !prev_busy) exp_sum = '0;
        check("ready_rule", 32'(rx_ready_o), 32'(busy_o && !we));
        check("core_rst_rule", 32'(core_rst_no), 32'(done_o));
        check("flag_exclusive", 32'(int'(busy_o) + int'(done_o) + int'(err_o) > 1), 32'd0);
        check("checksum", checksum_o, exp_sum);
        if (we) begin
          check("we_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("we_addr", 32'(addr), 32'(e.a));
            check("we_data", data, e.d);
          end
          exp_sum   = exp_sum + data;
          nwrites++;
          last_addr = addr;
        end
      end
      prev_busy = busy_o;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_byte  = b;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns in the cycle after the final byte (the last write strobe, or DONE/ERR for a header-only image).
  task automatic run_image(input int n, input int gap);
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AddrW'(i), img[i]});
      send_word(img[i]);
      if (gap > 0 && i == 0 && n > 1) begin
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        check("gap_no_err", 32'(err_o), 32'd0);
        check("gap_busy", 32'(busy_o), 32'd1);
      end
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; nwrites = 0; exp_sum = '0; prev_busy = 1'b0; last_addr = '0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("rst_core_rst_no", 32'(core_rst_no), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(rx_ready_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Basic three-word image
    img[0] = 32'h0000_0013; img[1] = 32'hDEAD_BEEF; img[2] = 32'h1234_5678;
    pulse_start();
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_ready", 32'(rx_ready_o), 32'd1);
    w0 = nwrites;
    run_image(3, 0);
    check("last_we", 32'(we), 32'd1);
    check("last_done_early", 32'(done_o), 32'd0);
    @(negedge clk);
    check("basic_done", 32'(done_o), 32'd1);
    check("basic_core_rst", 32'(core_rst_no), 32'd1);
    check("basic_checksum", checksum_o, 32'hF0E2_157A);
    check("basic_writes", 32'(nwrites - w0), 32'd3);
    check("basic_last_addr", 32'(last_addr), 32'd2);
    check("done_ready", 32'(rx_ready_o), 32'd0);

    // Restart from DONE, N=1
    pulse_start();
    check("restart_core_rst", 32'(core_rst_no), 32'd0);
    check("restart_done_clr", 32'(done_o), 32'd0);
    img[0] = 32'hA5A5_0001;
    w0 = nwrites;
    run_image(1, 0);
    @(negedge clk);
    check("n1_done", 32'(done_o), 32'd1);
    check("n1_addr", 32'(last_addr), 32'd0);
    check("n1_writes", 32'(nwrites - w0), 32'd1);
    check("n1_checksum", checksum_o, 32'hA5A5_0001);

    // Empty header
    pulse_start();
    w0 = nwrites;
    run_image(0, 0);
    check("n0_done", 32'(done_o), 32'd1);
    check("n0_core_rst", 32'(core_rst_no), 32'd1);
    repeat (3) @(negedge clk);
    check("n0_no_write", 32'(nwrites - w0), 32'd0);

    // Oversize header
    pulse_start();
    send_word(32'd4097);
    rx_valid = 1'b0;
    check("n4097_err", 32'(err_o), 32'd1);
    check("n4097_core_rst", 32'(core_rst_no), 32'd0);
    repeat (3) @(negedge clk);
    check("n4097_err_hold", 32'(err_o), 32'd1);

    // Timeout inside a payload word
    pulse_start();
    check("err_cleared", 32'(err_o), 32'd0);
    send_word(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("tmo_not_yet", 32'(err_o), 32'd0);
    repeat (10) @(negedge clk);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_core_rst", 32'(core_rst_no), 32'd0);

    // Long idle between whole words is legal
    img[0] = 32'h0BAD_F00D; img[1] = 32'h7777_0000;
    pulse_start();
    run_image(2, 100);
    @(negedge clk);
    check("gap_done", 32'(done_o), 32'd1);
    check("gap_checksum", checksum_o, 32'h0BAD_F00D + 32'h7777_0000);

    // start_i during LOAD is ignored
    img[0] = 32'hCAFE_0102; img[1] = 32'h0000_0F0F;
    pulse_start();
    send_word(32'd2);
    exp_q.push_back({AddrW'(0), img[0]});
    send_byte(img[0][7:0]);
    send_byte(img[0][15:8]);
    start = 1'b1;
    send_byte(img[0][23:16]);
    start = 1'b0;
    send_byte(img[0][31:24]);
    exp_q.push_back({AddrW'(1), img[1]});
    send_word(img[1]);
    rx_valid = 1'b0;
    @(negedge clk);
    check("ignore_done", 32'(done_o), 32'd1);
    check("ignore_checksum", checksum_o, 32'hCAFE_0102 + 32'h0000_0F0F);

    // Asynchronous reset in the middle of the second word
    img[0] = 32'h1111_2222; img[1] = 32'h3333_4444; img[2] = 32'h5555_6666;
    pulse_start();
    send_word(32'd3);
    exp_q.push_back({AddrW'(0), img[0]});
    send_word(img[0]);
    send_byte(img[1][7:0]);
    send_byte(img[1][15:8]);
    rx_byte = img[1][23:16];
    #2 rst_ni = 1'b0;
    #1;
    check("arst_ctrl", 32'({rx_ready_o, we, core_rst_no, busy_o, done_o, err_o}), 32'd0);
    check("arst_checksum", checksum_o, 32'd0);
    check("arst_data", data, 32'd0);
    check("arst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rx_valid = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    pulse_start();
    run_image(2, 0);
    @(negedge clk);
    check("arst_reload_done", 32'(done_o), 32'd1);
    check("arst_reload_sum", checksum_o, 32'h1111_2222 + 32'h3333_4444);

    // Full-depth image
    for (int i = 0; i < 4096; i++) img[i] = 32'(i) * 32'h9E37_79B9 + 32'h0000_1234;
    pulse_start();
    w0 = nwrites;
    run_image(4096, 0);
    @(negedge clk);
    check("full_done", 32'(done_o), 32'd1);
    check("full_writes", 32'(nwrites - w0), 32'd4096);
    check("full_last_addr", 32'(last_addr), 32'h0000_0FFF);
    check("full_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
